// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared definitions for the toggle-flip-flop counter family
package tff_pkg;

  localparam int TFF_MAX_WIDTH = 16;

  // Clamp a load value into the counter range: min(d, mod-1).
  function automatic logic [TFF_MAX_WIDTH-1:0] sat_load(
    input logic [TFF_MAX_WIDTH-1:0] d,
    input int unsigned              mod
  );
    if ({16'b0, d} >= mod) begin
      return TFF_MAX_WIDTH'(mod - 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with asynchronous active-low clear
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_sync_counter.sv
// rtl/tff_sync_counter.sv - modulo-MOD up/down counter built from a bank of T flip-flops
module tff_sync_counter
  import tff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] t_vec
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] nxt;

  // Wrap is tested before the +/-1, so the arithmetic never leaves 0..MOD-1.
  always_comb begin
    nxt = q;
    if (load) begin
      nxt = WIDTH'(sat_load(TFF_MAX_WIDTH'(d), 32'(MOD)));
    end else if (en) begin
      if (up_dn) begin
        nxt = (q == MAX_Q) ? '0 : q + WIDTH'(1);
      end else begin
        nxt = (q == '0) ? MAX_Q : q - WIDTH'(1);
      end
    end
  end

  assign t_vec = q ^ nxt;
  assign tc    = en & ~load & ((up_dn & (q == MAX_Q)) | (~up_dn & (q == '0)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

endmodule

// File: tb/tb_tff_sync_counter.sv
// tb/tb_tff_sync_counter.sv - directed bench for MOD=16 and MOD=10 counters
module tb_tff_sync_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en16, up16, load16;
  logic [3:0] d16, q16, tv16;
  logic       tc16;
  logic       en10, up10, load10;
  logic [3:0] d10, q10, tv10;
  logic       tc10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tff_sync_counter #(.WIDTH(4), .MOD(16)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .up_dn(up16), .load(load16),
    .d(d16), .q(q16), .tc(tc16), .t_vec(tv16)
  );

  tff_sync_counter #(.WIDTH(4), .MOD(10)) u10 (
    .clk(clk), .rst_n(rst_n), .en(en10), .up_dn(up10), .load(load10),
    .d(d10), .q(q10), .tc(tc10), .t_vec(tv10)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en16 = 1'b1; up16 = 1'b1; load16 = 1'b0; d16 = 4'd0;
    en10 = 1'b1; up10 = 1'b1; load10 = 1'b0; d10 = 4'd0;
    repeat (3) tick();
    n_tests++;
    if (q10 !== 4'd0) begin
      n_fail++; $display("FAIL reset_q10: got %0d expected 0", q10);
    end
    n_tests++;
    if (q16 !== 4'd0) begin
      n_fail++; $display("FAIL reset_q16: got %0d expected 0", q16);
    end
    n_tests++;
    if (tv10 !== 4'b0001) begin
      n_fail++; $display("FAIL reset_tvec: got %b expected 0001", tv10);
    end
    n_tests++;
    if (tc10 !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc: got %b expected 0", tc10);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (q10 !== 4'd1) begin
      n_fail++; $display("FAIL reset_first_edge: got %0d expected 1", q10);
    end
    en16 = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (q10 !== 4'd7) begin
      n_fail++; $display("FAIL reset_reach7: got %0d expected 7", q10);
    end
    en10 = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (q10 !== 4'd0) begin
      n_fail++; $display("FAIL reset_async: got %0d expected 0", q10);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (q10 !== 4'd0) begin
      n_fail++; $display("FAIL reset_release_hold: got %0d expected 0", q10);
    end
  endtask

  task automatic test_up_mod10();
    logic [3:0] prev;
    logic [3:0] exp;
    en10 = 1'b1; up10 = 1'b1; load10 = 1'b0;
    prev = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      n_tests++;
      if (tc10 !== (prev == 4'd9)) begin
        n_fail++; $display("FAIL up_tc step %0d: got %b expected %b", k, tc10, (prev == 4'd9));
      end
      if (prev == 4'd9) begin
        n_tests++;
        if (tv10 !== 4'b1001) begin
          n_fail++; $display("FAIL up_tvec_wrap: got %b expected 1001", tv10);
        end
      end
      tick();
      exp = 4'(k % 10);
      n_tests++;
      if (q10 !== exp) begin
        n_fail++; $display("FAIL up_q step %0d: got %0d expected %0d", k, q10, exp);
      end
      prev = exp;
    end
    en10 = 1'b0;
  endtask

  task automatic test_down_mod10();
    logic [3:0] prev;
    logic [3:0] exp;
    load10 = 1'b1; d10 = 4'd0;
    tick();
    load10 = 1'b0;
    n_tests++;
    if (q10 !== 4'd0) begin
      n_fail++; $display("FAIL down_load0: got %0d expected 0", q10);
    end
    en10 = 1'b1; up10 = 1'b0;
    #1;
    n_tests++;
    if (tv10 !== 4'b1001) begin
      n_fail++; $display("FAIL down_tvec_wrap: got %b expected 1001", tv10);
    end
    prev = 4'd0;
    for (int k = 1; k <= 11; k++) begin
      n_tests++;
      if (tc10 !== (prev == 4'd0)) begin
        n_fail++; $display("FAIL down_tc step %0d: got %b expected %b", k, tc10, (prev == 4'd0));
      end
      tick();
      exp = 4'((10 - k) % 10);
      if (k == 11) exp = 4'd9;
      n_tests++;
      if (q10 !== exp) begin
        n_fail++; $display("FAIL down_q step %0d: got %0d expected %0d", k, q10, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_load();
    en10 = 1'b1; up10 = 1'b1; load10 = 1'b1; d10 = 4'd6;
    #1;
    n_tests++;
    if (tc10 !== 1'b0) begin
      n_fail++; $display("FAIL load_tc_wrap: got %b expected 0", tc10);
    end
    tick();
    n_tests++;
    if (q10 !== 4'd6) begin
      n_fail++; $display("FAIL load_d6: got %0d expected 6", q10);
    end
    d10 = 4'd13;
    load16 = 1'b1; d16 = 4'd13;
    tick();
    n_tests++;
    if (q10 !== 4'd9) begin
      n_fail++; $display("FAIL load_sat10: got %0d expected 9", q10);
    end
    n_tests++;
    if (q16 !== 4'd13) begin
      n_fail++; $display("FAIL load_d13_mod16: got %0d expected 13", q16);
    end
    d16 = 4'd15;
    tick();
    n_tests++;
    if (q16 !== 4'd15) begin
      n_fail++; $display("FAIL load_d15_mod16: got %0d expected 15", q16);
    end
    load10 = 1'b0; load16 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    en10 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up10 = (k % 2 == 0);
      #1;
      n_tests++;
      if (tc10 !== 1'b1) begin
        n_fail++; $display("FAIL alt_tc step %0d: got %b expected 1", k, tc10);
      end
      tick();
      exp = (k % 2 == 0) ? 4'd0 : 4'd9;
      n_tests++;
      if (q10 !== exp) begin
        n_fail++; $display("FAIL alt_q step %0d: got %0d expected %0d", k, q10, exp);
      end
    end
    en10 = 1'b0;
  endtask

  task automatic test_hold_toggle();
    logic [3:0] cnt;
    logic [3:0] tv_exp;
    load16 = 1'b1; d16 = 4'b0111; en16 = 1'b0;
    tick();
    load16 = 1'b0;
    n_tests++;
    if (q16 !== 4'd7) begin
      n_fail++; $display("FAIL hold_load7: got %0d expected 7", q16);
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (tv16 !== 4'b0000) begin
        n_fail++; $display("FAIL hold_tvec step %0d: got %b expected 0000", k, tv16);
      end
      tick();
      n_tests++;
      if (q16 !== 4'd7) begin
        n_fail++; $display("FAIL hold_q step %0d: got %0d expected 7", k, q16);
      end
    end
    en16 = 1'b1; up16 = 1'b1;
    #1;
    n_tests++;
    if (tv16 !== 4'b1111) begin
      n_fail++; $display("FAIL toggle_tvec_7: got %b expected 1111", tv16);
    end
    tick();
    n_tests++;
    if (q16 !== 4'b1000) begin
      n_fail++; $display("FAIL toggle_q_8: got %b expected 1000", q16);
    end
    cnt = 4'b1000;
    for (int k = 0; k < 16; k++) begin
      tv_exp = {&cnt[2:0], &cnt[1:0], cnt[0], 1'b1};
      n_tests++;
      if (tv16 !== tv_exp) begin
        n_fail++; $display("FAIL identity_tvec at %0d: got %b expected %b", cnt, tv16, tv_exp);
      end
      tick();
      cnt = cnt + 4'd1;
      n_tests++;
      if (q16 !== cnt) begin
        n_fail++; $display("FAIL identity_q: got %0d expected %0d", q16, cnt);
      end
    end
    en16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_mod10();
    test_down_mod10();
    test_load();
    test_back_to_back();
    test_hold_toggle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
